// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write-port arbiter: each requester owns a one-entry
// holding slot, slots are drained round-robin into registered write-port outputs.
module wb_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  input  logic        rf_hold,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        sel,
  output logic [1:0]  pending
);

  logic        full0_q, full0_d, full1_q, full1_d;
  logic [4:0]  addr0_q, addr0_d, addr1_q, addr1_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic        last_grant_q, last_grant_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        sel_q, sel_d;

  logic        grant_vld, grant_idx, grant0, grant1, acc0, acc1;
  logic [4:0]  g_addr;
  logic [31:0] g_data;

  // Arbitration and handshake: ties go to the slot not granted last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (rf_hold) begin
      grant_vld = 1'b0;
      grant_idx = 1'b0;
    end else begin
      case ({full1_q, full0_q})
        2'b01:   begin grant_vld = 1'b1; grant_idx = 1'b0;          end
        2'b10:   begin grant_vld = 1'b1; grant_idx = 1'b1;          end
        2'b11:   begin grant_vld = 1'b1; grant_idx = ~last_grant_q; end
        default: begin grant_vld = 1'b0; grant_idx = 1'b0;          end
      endcase
    end
    grant0     = grant_vld & ~grant_idx;
    grant1     = grant_vld & grant_idx;
    g_addr     = grant_idx ? addr1_q : addr0_q;
    g_data     = grant_idx ? data1_q : data0_q;
    // Slots read as empty while reset is applied.
    req0_ready = rst | ~full0_q | grant0;
    req1_ready = rst | ~full1_q | grant1;
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
  end

  // Next-state for slots, round-robin pointer and write-port registers.
  always_comb begin
    full0_d = (full0_q & ~grant0) | acc0;
    full1_d = (full1_q & ~grant1) | acc1;
    addr0_d = acc0 ? req0_addr : addr0_q;
    data0_d = acc0 ? req0_data : data0_q;
    addr1_d = acc1 ? req1_addr : addr1_q;
    data1_d = acc1 ? req1_data : data1_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    sel_d        = sel_q;
    if (grant_vld) begin
      // Register 0 writes still drain the slot and count for round-robin.
      rf_we_d      = (g_addr != 5'd0);
      rf_waddr_d   = g_addr;
      rf_wdata_d   = g_data;
      sel_d        = grant_idx;
      last_grant_d = grant_idx;
    end else begin
      rf_we_d      = 1'b0;
      last_grant_d = last_grant_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      full0_q      <= 1'b0;
      full1_q      <= 1'b0;
      addr0_q      <= 5'd0;
      data0_q      <= 32'd0;
      addr1_q      <= 5'd0;
      data1_q      <= 32'd0;
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
      sel_q        <= 1'b0;
    end else begin
      full0_q      <= full0_d;
      full1_q      <= full1_d;
      addr0_q      <= addr0_d;
      data0_q      <= data0_d;
      addr1_q      <= addr1_d;
      data1_q      <= data1_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      sel_q        <= sel_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign sel      = sel_q;
  assign pending  = {full1_q, full0_q};

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rf_hold = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr = 5'd0, req1_addr = 5'd0;
  logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
  logic        rf_we, sel;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  pending;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sel(sel), .pending(pending)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  // Reference model: per-requester queues of accepted, not yet issued writes.
  wr_t         q0[$];
  wr_t         q1[$];
  logic        m_last = 1'b1, m_we = 1'b0, m_sel = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  logic        m_r0, m_r1, s_r0, s_r1;

  typedef struct {
    logic        rst, v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        hold, r0, r1, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sel;
    logic [1:0]  pend;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, check ready before the edge, check registers after it.
  task automatic step(input logic r, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1, input logic h);
    int  win;
    wr_t w;
    rst = r; req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1; rf_hold = h;
    #2;
    if (h || (q0.size() == 0 && q1.size() == 0)) win = -1;
    else if (q0.size() != 0 && q1.size() != 0) win = m_last ? 0 : 1;
    else win = (q0.size() != 0) ? 0 : 1;
    m_r0 = r || q0.size() == 0 || win == 0;
    m_r1 = r || q1.size() == 0 || win == 1;
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    chk("req0_ready", 32'(s_r0), 32'(m_r0));
    chk("req1_ready", 32'(s_r1), 32'(m_r1));
    @(posedge clk);
    if (r) begin
      q0.delete(); q1.delete();
      m_last = 1'b1; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_sel = 1'b0;
    end else begin
      w = '0;
      if (win == 0) w = q0.pop_front();
      else if (win == 1) w = q1.pop_front();
      if (win >= 0) begin
        m_we = (w.a != 5'd0); m_waddr = w.a; m_wdata = w.d;
        m_sel = (win == 1); m_last = (win == 1);
      end else begin
        m_we = 1'b0;
      end
      if (v0 && m_r0) q0.push_back({a0, d0});
      if (v1 && m_r1) q1.push_back({a1, d1});
    end
    #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("sel", 32'(sel), 32'(m_sel));
    chk("pending", 32'(pending), 32'({q1.size() != 0, q0.size() != 0}));
  endtask

  task automatic idle(input logic h);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, h);
  endtask

  initial begin
    logic        o0v, o1v, rr, hh;
    logic [4:0]  o0a, o1a;
    logic [31:0] o0d, o1d;
    int          s0, s1;

    //          rst  v0   a0     d0             v1   a1     d1          hold r0   r1   we   waddr  wdata          sel  pend
    tbl[0]  = '{1'b1,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b0,1'b1,1'b1,1'b0,5'd0,32'd0,          1'b0,2'b00};
    tbl[1]  = '{1'b0,1'b1,5'd5,32'hDEADBEEF,   1'b0,5'd0,32'd0,      1'b0,1'b1,1'b1,1'b0,5'd0,32'd0,          1'b0,2'b01};
    tbl[2]  = '{1'b0,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b0,1'b1,1'b1,1'b1,5'd5,32'hDEADBEEF,   1'b0,2'b00};
    tbl[3]  = '{1'b0,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b0,1'b1,1'b1,1'b0,5'd5,32'hDEADBEEF,   1'b0,2'b00};
    tbl[4]  = '{1'b0,1'b0,5'd0,32'd0,          1'b1,5'd0,32'h1234,   1'b0,1'b1,1'b1,1'b0,5'd5,32'hDEADBEEF,   1'b0,2'b10};
    tbl[5]  = '{1'b0,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b0,1'b1,1'b1,1'b0,5'd0,32'h1234,       1'b1,2'b00};
    tbl[6]  = '{1'b0,1'b1,5'd3,32'hA0,         1'b1,5'd4,32'hB1,     1'b0,1'b1,1'b1,1'b0,5'd0,32'h1234,       1'b1,2'b11};
    tbl[7]  = '{1'b0,1'b1,5'd7,32'hC0,         1'b0,5'd0,32'd0,      1'b1,1'b0,1'b0,1'b0,5'd0,32'h1234,       1'b1,2'b11};
    tbl[8]  = '{1'b0,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b1,1'b0,1'b0,1'b0,5'd0,32'h1234,       1'b1,2'b11};
    tbl[9]  = '{1'b0,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b1,1'b0,1'b0,1'b0,5'd0,32'h1234,       1'b1,2'b11};
    tbl[10] = '{1'b0,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b0,1'b1,1'b0,1'b1,5'd3,32'hA0,         1'b0,2'b10};
    tbl[11] = '{1'b0,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b0,1'b1,1'b1,1'b1,5'd4,32'hB1,         1'b1,2'b00};
    tbl[12] = '{1'b0,1'b0,5'd0,32'd0,          1'b0,5'd0,32'd0,      1'b0,1'b1,1'b1,1'b0,5'd4,32'hB1,         1'b1,2'b00};

    @(posedge clk);
    #1;

    // Directed table: single write, register 0 drain, tie after hold.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].hold);
      chk($sformatf("tbl%0d_r0", i), 32'(s_r0), 32'(tbl[i].r0));
      chk($sformatf("tbl%0d_r1", i), 32'(s_r1), 32'(tbl[i].r1));
      chk($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].waddr));
      chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].wdata);
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_pend", i), 32'(pending), 32'(tbl[i].pend));
    end

    // Round-robin with both requesters continuously valid.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    s0 = 0; s1 = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, s0 < 4, 5'(s0 + 1), 32'(100 + s0), s1 < 4, 5'(s1 + 9), 32'(200 + s1), 1'b0);
      if (s0 < 4 && m_r0) s0++;
      if (s1 < 4 && m_r1) s1++;
      if (c >= 1 && c <= 8) begin
        chk("rr_we", 32'(rf_we), 32'd1);
        chk("rr_sel", 32'(sel), 32'((c - 1) % 2));
      end
      if (c == 9) chk("rr_we_end", 32'(rf_we), 32'd0);
    end

    // Reset with both slots full discards them.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0);
    step(1'b1, 1'b1, 5'd13, 32'hCC, 1'b1, 5'd14, 32'hDD, 1'b0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    for (int c = 0; c < 3; c++) begin
      idle(1'b0);
      chk("rst_no_stale", 32'(rf_we), 32'd0);
    end
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h55, 1'b0);
    idle(1'b0);
    chk("rst_new_we", 32'(rf_we), 32'd1);
    chk("rst_new_sel", 32'(sel), 32'd1);
    chk("rst_new_addr", 32'(rf_waddr), 32'd12);

    // Back-to-back writes from requester 0 alone.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 5'(i + 1), 32'(300 + i), 1'b0, 5'd0, 32'd0, 1'b0);
      chk("b2b_ready", 32'(s_r0), 32'd1);
      if (i >= 1) chk("b2b_addr", 32'(rf_waddr), 32'(i));
    end
    idle(1'b0);
    chk("b2b_last_addr", 32'(rf_waddr), 32'd6);
    chk("b2b_last_we", 32'(rf_we), 32'd1);

    // Randomized traffic; requesters hold an offer until it is accepted.
    o0v = 1'b0; o1v = 1'b0; o0a = 5'd0; o1a = 5'd0; o0d = 32'd0; o1d = 32'd0;
    for (int c = 0; c < 400; c++) begin
      if (!o0v) begin
        o0v = ($urandom_range(0, 2) != 0);
        o0a = 5'($urandom_range(0, 31));
        o0d = $urandom;
      end
      if (!o1v) begin
        o1v = ($urandom_range(0, 2) != 0);
        o1a = 5'($urandom_range(0, 31));
        o1d = $urandom;
      end
      rr = ($urandom_range(0, 49) == 0);
      hh = ($urandom_range(0, 3) == 0);
      step(rr, o0v, o0a, o0d, o1v, o1a, o1d, hh);
      if (!rr && o0v && m_r0) o0v = 1'b0;
      if (!rr && o1v && m_r1) o1v = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
